// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two byte producers, the arbiter and the shared UART transmitter.
// The arbiter connects through the slave modport; the producer/transmitter side uses master.
interface uart_tx_arbiter_if;
    logic       i_a_stb;
    logic [7:0] i_a_data;
    logic       o_a_busy;
    logic       i_b_stb;
    logic [7:0] i_b_data;
    logic       o_b_busy;
    logic       o_tx_stb;
    logic [7:0] o_tx_data;
    logic       i_tx_busy;
    logic [1:0] o_grant;

    modport slave (
        input  i_a_stb, i_a_data, i_b_stb, i_b_data, i_tx_busy,
        output o_a_busy, o_b_busy, o_tx_stb, o_tx_data, o_grant
    );

    modport master (
        output i_a_stb, i_a_data, i_b_stb, i_b_data, i_tx_busy,
        input  o_a_busy, o_b_busy, o_tx_stb, o_tx_data, o_grant
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between channel A (rx echo) and B (messages).
// Define UARTARB_FIFO_EN to replace channel A's holding register with a 2**FIFO_LW-entry FIFO.
module uart_tx_arbiter #(
    parameter int FIFO_LW = 2
) (
    input  logic               CLK,
    input  logic               RST_N,
    uart_tx_arbiter_if.slave   bus
);

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t     state_q, state_d;
    logic       tx_stb_q, tx_stb_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [1:0] grant_q, grant_d;
    logic       ptr_q, ptr_d;          // 0: favour A on contention, 1: favour B
    logic       b_valid_q, b_valid_d;
    logic [7:0] b_data_q, b_data_d;

    logic       a_valid;
    logic [7:0] a_head;
    logic       a_busy;
    logic       a_sel;
    logic       b_sel;

`ifdef UARTARB_FIFO_EN
    localparam int DEPTH = 1 << FIFO_LW;
    localparam logic [FIFO_LW:0] FULL_COUNT = {1'b1, {FIFO_LW{1'b0}}};

    logic [7:0]         a_mem [DEPTH];
    logic [FIFO_LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_LW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_LW:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               a_push;
    logic               a_pop;

    // The head entry stays in the FIFO until the transmitter takes it, so the
    // byte in flight still occupies a slot.
    assign a_push = bus.i_a_stb && !full_q;
    assign a_pop  = (state_q == S_SEND) && grant_q[0] && !bus.i_tx_busy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (a_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (a_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({a_push, a_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d = (count_d == FULL_COUNT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (a_push) a_mem[wr_ptr_q] <= bus.i_a_data;
    end

    assign a_valid = (count_q != '0);
    assign a_head  = a_mem[rd_ptr_q];
    assign a_busy  = full_q;
`else
    logic       a_valid_q, a_valid_d;
    logic [7:0] a_data_q, a_data_d;

    always_comb begin
        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        if (a_sel) a_valid_d = 1'b0;
        if (bus.i_a_stb && !a_valid_q) begin
            a_valid_d = 1'b1;
            a_data_d  = bus.i_a_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
        end else begin
            a_valid_q <= a_valid_d;
            a_data_q  <= a_data_d;
        end
    end

    assign a_valid = a_valid_q;
    assign a_head  = a_data_q;
    assign a_busy  = a_valid_q;
`endif

    always_comb begin
        b_valid_d = b_valid_q;
        b_data_d  = b_data_q;
        if (b_sel) b_valid_d = 1'b0;
        if (bus.i_b_stb && !b_valid_q) begin
            b_valid_d = 1'b1;
            b_data_d  = bus.i_b_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_stb_d  = tx_stb_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_stb_d = 1'b0;
                if (a_valid && (!b_valid_q || !ptr_q)) a_sel = 1'b1;
                else if (b_valid_q)                    b_sel = 1'b1;
                if (a_sel) begin
                    tx_data_d = a_head;
                    tx_stb_d  = 1'b1;
                    grant_d   = 2'b01;
                    state_d   = S_SEND;
                end else if (b_sel) begin
                    tx_data_d = b_data_q;
                    tx_stb_d  = 1'b1;
                    grant_d   = 2'b10;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                // Transmitter accepts: hand priority to the channel not just served.
                if (!bus.i_tx_busy) begin
                    tx_stb_d = 1'b0;
                    grant_d  = 2'b00;
                    ptr_d    = grant_q[0];
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            tx_stb_q  <= 1'b0;
            tx_data_q <= '0;
            grant_q   <= 2'b00;
            ptr_q     <= 1'b0;
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            tx_stb_q  <= tx_stb_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            b_valid_q <= b_valid_d;
            b_data_q  <= b_data_d;
        end
    end

    assign bus.o_a_busy  = a_busy;
    assign bus.o_b_busy  = b_valid_q;
    assign bus.o_tx_stb  = tx_stb_q;
    assign bus.o_tx_data = tx_data_q;
    assign bus.o_grant   = grant_q;

endmodule
